// File: rtl/opf_pkg.sv
// Shared types and constants for the operand fetch controller.
package opf_pkg;

    localparam int ADDR_W = 12;

    // Page-zero window whose pointers auto-increment (OPF_AUTOINC_EN builds).
    localparam logic [ADDR_W-1:0] AUTOINC_LO = 12'h008;
    localparam logic [ADDR_W-1:0] AUTOINC_HI = 12'h00F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PTR_RD = 3'd1,
        ST_PTR_WB = 3'd2,
        ST_OPR_RD = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic is_autoinc(input logic [ADDR_W-1:0] addr);
        return (addr >= AUTOINC_LO) && (addr <= AUTOINC_HI);
    endfunction

endpackage

// File: rtl/opf_addr_form.sv
// Base address formation: page-zero or current-page concatenated with offset.
module opf_addr_form
    import opf_pkg::*;
(
    input  logic              cur_page,
    input  logic [4:0]        page,
    input  logic [6:0]        offset,
    output logic [ADDR_W-1:0] base
);

    assign base = {(cur_page ? page : 5'b0), offset};

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: direct / indirect operand fetch over a simple
// req/ack memory port. Optional pointer auto-increment with write-back is
// enabled by defining OPF_AUTOINC_EN.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | waiting for start; inputs captured when start is accepted
// ST_PTR_RD | reading the pointer word at the base address
// ST_PTR_WB | writing the incremented pointer back (auto-increment only)
// ST_OPR_RD | reading the operand at the effective address
// ST_DONE   | one-cycle done pulse, then back to idle
//
// Every memory state spends one cycle with mem_req low before raising it,
// which provides the mandatory idle cycle between back-to-back transfers.
module operand_fetch_ctrl
    import opf_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [4:0]        page,
    input  logic [6:0]        offset,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] operand,
    output logic [ADDR_W-1:0] eff_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] eff_addr_q, eff_addr_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
`ifdef OPF_AUTOINC_EN
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
`endif

    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] ptr_c;

    opf_addr_form u_addr_form (
        .cur_page (mode[0]),
        .page     (page),
        .offset   (offset),
        .base     (base_c)
    );

    assign ptr_c = mem_rdata[ADDR_W-1:0];

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        eff_addr_d = eff_addr_q;
        operand_d  = operand_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
`ifdef OPF_AUTOINC_EN
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = base_c;
                    if (mode[1]) begin
                        state_d = ST_PTR_RD;
                    end else begin
                        eff_addr_d = base_c;
                        state_d    = ST_OPR_RD;
                    end
                end
            end
            ST_PTR_RD: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = base_q;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
`ifdef OPF_AUTOINC_EN
                    if (is_autoinc(base_q)) begin
                        eff_addr_d = ptr_c + 12'd1;
                        state_d    = ST_PTR_WB;
                    end else begin
                        eff_addr_d = ptr_c;
                        state_d    = ST_OPR_RD;
                    end
`else
                    eff_addr_d = ptr_c;
                    state_d    = ST_OPR_RD;
`endif
                end
            end
`ifdef OPF_AUTOINC_EN
            ST_PTR_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q;
                    mem_wdata_d = DATA_W'(eff_addr_q);
                end else if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    state_d     = ST_OPR_RD;
                end
            end
`endif
            ST_OPR_RD: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = eff_addr_q;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    operand_d = mem_rdata;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            eff_addr_q <= '0;
            operand_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
`ifdef OPF_AUTOINC_EN
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            eff_addr_q <= eff_addr_d;
            operand_q  <= operand_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
`ifdef OPF_AUTOINC_EN
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign operand  = operand_q;
    assign eff_addr = eff_addr_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
`ifdef OPF_AUTOINC_EN
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`else
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
`endif

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: vector table plus hand-written corner sequences.
// Expectations follow the OPF_AUTOINC_EN setting of the build.
module tb_operand_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [4:0]  page;
    logic [6:0]  offset;
    logic        busy, done, mem_req, mem_we, mem_ack;
    logic [11:0] operand, eff_addr, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    operand_fetch_ctrl #(.DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .page(page),
        .offset(offset), .busy(busy), .done(done), .operand(operand),
        .eff_addr(eff_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    // Memory model: ack after dly extra cycles of mem_req; spur forces ack always.
    logic [11:0] mem [0:4095];
    int          dly = 0;
    bit          spur = 1'b0;
    int          wcnt = 0;

    assign mem_ack   = (mem_req && (wcnt >= dly)) || spur;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

    // Transfer log, write commit, handshake stability and done counting.
    int          nx = 0, nwr = 0, ndone = 0, stab_bad = 0;
    logic [11:0] x0a = '0, wra = '0, wrd = '0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [11:0] p_addr = '0, p_wd = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack) begin
                if (nx == 0) x0a = mem_addr;
                nx++;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    nwr++;
                    wra = mem_addr;
                    wrd = mem_wdata;
                end
            end
            if (p_req && !p_ack && mem_req &&
                ({mem_addr, mem_we, mem_wdata} != {p_addr, p_we, p_wd})) stab_bad++;
            if (p_req && p_ack && mem_req) stab_bad++;
            if (done) ndone++;
        end
        p_req  = mem_req;
        p_ack  = mem_ack;
        p_we   = mem_we;
        p_addr = mem_addr;
        p_wd   = mem_wdata;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        nx = 0; nwr = 0; ndone = 0;
    endtask

    // Issue one start and wait (bounded) for done; lat counts cycles after start's cycle.
    task automatic run_op(input logic [1:0] m, input logic [4:0] pg, input logic [6:0] off,
                          output int lat);
        clear_log();
        @(negedge clk);
        mode = m; page = pg; offset = off; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [4:0]  pg;
        logic [6:0]  off;
        int          d;
        logic [11:0] a0, d0, a1, d1, a2, d2;
        logic [11:0] x0, op, ea;
        int          lat, nx, nwr;
        logic [11:0] wa, wd;
    } vec_t;

    vec_t v [8];

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; mode = '0; page = '0; offset = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        v[0] = '{2'b00, 5'h1F, 7'h05, 0, 12'h005, 12'h123, 12'h005, 12'h123, 12'h005, 12'h123,
                 12'h005, 12'h123, 12'h005, 3, 1, 0, 12'h000, 12'h000};
        v[1] = '{2'b01, 5'h02, 7'h10, 2, 12'h110, 12'h5A5, 12'h110, 12'h5A5, 12'h110, 12'h5A5,
                 12'h110, 12'h5A5, 12'h110, 5, 1, 0, 12'h000, 12'h000};
        v[2] = '{2'b11, 5'h01, 7'h00, 0, 12'h080, 12'h345, 12'h345, 12'h0AA, 12'h345, 12'h0AA,
                 12'h080, 12'h0AA, 12'h345, 5, 2, 0, 12'h000, 12'h000};
`ifdef OPF_AUTOINC_EN
        v[3] = '{2'b10, 5'h1F, 7'h08, 0, 12'h008, 12'hFFF, 12'h000, 12'h777, 12'hFFF, 12'h0BE,
                 12'h008, 12'h777, 12'h000, 7, 3, 1, 12'h008, 12'h000};
        v[6] = '{2'b10, 5'h03, 7'h0F, 1, 12'h00F, 12'h200, 12'h201, 12'h009, 12'h200, 12'h008,
                 12'h00F, 12'h009, 12'h201, 10, 3, 1, 12'h00F, 12'h201};
`else
        v[3] = '{2'b10, 5'h1F, 7'h08, 0, 12'h008, 12'hFFF, 12'h000, 12'h777, 12'hFFF, 12'h0BE,
                 12'h008, 12'h0BE, 12'hFFF, 5, 2, 0, 12'h000, 12'h000};
        v[6] = '{2'b10, 5'h03, 7'h0F, 1, 12'h00F, 12'h200, 12'h201, 12'h009, 12'h200, 12'h008,
                 12'h00F, 12'h008, 12'h200, 7, 2, 0, 12'h000, 12'h000};
`endif
        v[4] = '{2'b11, 5'h01, 7'h08, 0, 12'h088, 12'h00C, 12'h00C, 12'h321, 12'h00C, 12'h321,
                 12'h088, 12'h321, 12'h00C, 5, 2, 0, 12'h000, 12'h000};
        v[5] = '{2'b10, 5'h00, 7'h07, 0, 12'h007, 12'h010, 12'h010, 12'h444, 12'h010, 12'h444,
                 12'h007, 12'h444, 12'h010, 5, 2, 0, 12'h000, 12'h000};
        v[7] = '{2'b10, 5'h00, 7'h10, 0, 12'h010, 12'h444, 12'h444, 12'h0FF, 12'h444, 12'h0FF,
                 12'h010, 12'h0FF, 12'h444, 5, 2, 0, 12'h000, 12'h000};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, operand, eff_addr}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven fetches.
        for (int i = 0; i < 8; i++) begin
            mem[v[i].a0] = v[i].d0;
            mem[v[i].a1] = v[i].d1;
            mem[v[i].a2] = v[i].d2;
            dly = v[i].d;
            run_op(v[i].m, v[i].pg, v[i].off, lat);
            check($sformatf("v%0d_latency", i), lat, v[i].lat);
            check($sformatf("v%0d_operand", i), operand, v[i].op);
            check($sformatf("v%0d_eff_addr", i), eff_addr, v[i].ea);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {done, busy}, 2'b00);
            check($sformatf("v%0d_xfers", i), nx, v[i].nx);
            check($sformatf("v%0d_first_addr", i), x0a, v[i].x0);
            check($sformatf("v%0d_writes", i), nwr, v[i].nwr);
            if (nwr > 0) check($sformatf("v%0d_wb", i), {wra, wrd}, {v[i].wa, v[i].wd});
            check($sformatf("v%0d_ndone", i), ndone, 1);
        end

        // Ack while mem_req low must not advance the fetch.
        dly = 0; spur = 1'b1;
        mem[12'h005] = 12'h123;
        run_op(2'b00, 5'h00, 7'h05, lat);
        spur = 1'b0;
        check("spur_latency", lat, 3);
        check("spur_operand", operand, 12'h123);
        @(negedge clk);

        // Starts and input changes while busy are ignored; results hold afterwards.
        clear_log();
        dly = 4;
        mem[12'h110] = 12'h5A5;
        @(negedge clk);
        mode = 2'b01; page = 5'h02; offset = 7'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            start = (lat >= 2 && lat <= 4);
            mode = 2'b00; offset = 7'h05;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("busy_start_latency", lat, 7);
        check("busy_start_operand", operand, 12'h5A5);
        check("busy_start_eff", eff_addr, 12'h110);
        repeat (6) @(negedge clk);
        check("hold_operand", operand, 12'h5A5);
        check("hold_eff", eff_addr, 12'h110);
        check("busy_start_ndone", ndone, 1);
        check("busy_start_xfers", nx, 1);

        // Reset in OPR_RD while an ack is pending.
        dly = 3;
        mode = 2'b00; page = 5'h00; offset = 7'h05;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!(mem_req && mem_ack) && lat < 50) begin
            start = ~start;
            @(negedge clk);
            lat++;
        end
        check("rst_wait_ack", (lat < 50), 1'b1);
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {busy, done, mem_req, mem_we, mem_addr, mem_wdata, operand, eff_addr}, 64'd0);
        clear_log();
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_ndone", ndone, 0);
        check("rst_mid_idle", {busy, operand, eff_addr}, 25'd0);

        check("handshake_stable", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
